sr_iter: RTL and testbench

Iterative 64-bit right shifter for the ALU shift path, the counterpart of the single-step left-shift stage. It accepts an operand and a 6-bit shift amount over a valid/ready handshake and shifts right by one bit per clock, logical or arithmetic. It presents the result on a valid/ready output handshake. It handles multi-bit right shifts where a full combinational barrel shifter is not wanted.

---
 rtl/sr_iter.sv | 75 +++++++
 tb/tb_sr_iter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/sr_iter.sv
// Iterative right shifter: accepts an operand over valid/ready, shifts it right one bit per clock
// (logical or arithmetic), then holds the result on a valid/ready output until it is consumed.
module sr_iter #(
    parameter int WIDTH = 64,
    parameter int SHW   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic             in_arith,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] data;
    logic [SHW-1:0]   count;
    logic             arith;
    logic             fill;

    // Arithmetic shifts replicate the current MSB, which is always the original sign bit.
    assign fill      = arith & data[WIDTH-1];

    // Handshake outputs come straight from the state register.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_data  = data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            data  <= '0;
            count <= '0;
            arith <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data  <= in_data;
                        count <= in_shamt;
                        arith <= in_arith;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (count != '0) begin
                        data  <= {fill, data[WIDTH-1:1]};
                        count <= count - SHW'(1);
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_iter.sv
// Self-checking bench for sr_iter: directed corner cases, backpressure, reset mid-shift and a
// randomized regression scored against a plain >> / >>> reference model.
module tb_sr_iter;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [5:0]  in_shamt;
    logic        in_arith;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;

    int checks   = 0;
    int failures = 0;

    sr_iter #(.WIDTH(64), .SHW(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_arith  (in_arith),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_shift(input logic [63:0] d, input int sh, input logic a);
        logic signed [63:0] s;
        s = d;
        if (a) return 64'(s >>> sh);
        return d >> sh;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: request, latency measurement, optional output stall, handshake.
    task automatic applyStimulus(input logic [63:0] d, input int sh, input logic a,
                                 input logic [63:0] exp, input int stall);
        int guard;
        int lat;
        logic [63:0] held;
        guard = 0;
        while (!in_ready && guard < 200) begin
            step();
            guard++;
        end
        checkOutput("in_ready_before_req", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = 6'(sh);
        in_arith = a;
        step();
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        in_shamt = 6'($urandom);
        in_arith = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            in_valid = 1'($urandom);
            step();
            lat++;
        end
        in_valid = 1'b0;
        checkOutput("latency", 64'(lat), 64'(sh + 1));
        checkOutput("result", out_data, exp);
        held = out_data;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'($urandom);
            in_data  = {$urandom, $urandom};
            step();
            checkOutput("stall_valid", 64'(out_valid), 64'd1);
            checkOutput("stall_data", out_data, held);
            checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checkOutput("post_hs_in_ready", 64'(in_ready), 64'd1);
        checkOutput("post_hs_out_valid", 64'(out_valid), 64'd0);
    endtask

    initial begin
        int seen_valid;
        logic [63:0] d;
        int sh;
        logic a;

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_shamt = '0;
        in_arith = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_out_data", out_data, 64'd0);

        $display("[TB] directed cases");
        applyStimulus(64'h0000_0000_0000_00F0, 4, 1'b0, 64'h0000_0000_0000_000F, 0);
        applyStimulus(64'h8000_0000_0000_0000, 4, 1'b1, 64'hF800_0000_0000_0000, 0);
        applyStimulus(64'h8000_0000_0000_0000, 4, 1'b0, 64'h0800_0000_0000_0000, 0);
        applyStimulus(64'h1234_5678_9ABC_DEF0, 0, 1'b1, 64'h1234_5678_9ABC_DEF0, 0);
        applyStimulus(64'h8000_0000_0000_0000, 63, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        applyStimulus(64'h8000_0000_0000_0000, 63, 1'b0, 64'h0000_0000_0000_0001, 0);

        $display("[TB] backpressure");
        applyStimulus(64'hC3C3_0000_FFFF_1234, 7, 1'b1, 64'hFF87_8600_01FF_FE24, 10);
        applyStimulus(64'h0000_0000_0000_0100, 8, 1'b0, 64'h0000_0000_0000_0001, 0);

        $display("[TB] reset mid-shift");
        in_valid = 1'b1;
        in_data  = 64'hFFFF_0000_FFFF_0000;
        in_shamt = 6'd20;
        in_arith = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_out_data", out_data, 64'd0);
        seen_valid = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (out_valid) seen_valid++;
        end
        checkOutput("midrst_no_result", 64'(seen_valid), 64'd0);
        applyStimulus(64'h2, 1, 1'b0, 64'h1, 0);

        $display("[TB] random regression");
        for (int n = 0; n < 1200; n++) begin
            d  = {$urandom, $urandom};
            sh = int'($urandom_range(0, 63));
            a  = 1'($urandom);
            applyStimulus(d, sh, a, ref_shift(d, sh, a), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
